// File: rtl/vga_pic_pkg.sv
// Shared types and constants for the VGA picture scheduler.
package vga_pic_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam logic [15:0] COLOR_BG     = 16'hFFFF;
  localparam logic [15:0] COLOR_BORDER = 16'hF800;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

endpackage

// File: rtl/vga_pic_mover.sv
// Picture position registers; one bounce step per update strobe.
module vga_pic_mover #(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int PIC_W   = 100,
  parameter int PIC_H   = 100,
  parameter int STEP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  output logic [9:0] pic_x0,
  output logic [9:0] pic_y0
);

  localparam logic [10:0] STEP_W = 11'(STEP);

  logic        dx;
  logic        dy;
  logic [10:0] x_nxt;
  logic [10:0] y_nxt;

  // Returns {next_dir, next_pos}; 11-bit sums keep pos+size+step from wrapping.
  function automatic logic [10:0] bounce(input logic [9:0]  pos,
                                         input logic        fwd,
                                         input logic [10:0] span,
                                         input logic [10:0] size);
    logic [10:0] p;
    p = {1'b0, pos};
    if (fwd) begin
      if (p + size + STEP_W > span) return {1'b0, 10'(p - STEP_W)};
      else                          return {1'b1, 10'(p + STEP_W)};
    end else begin
      if (p < STEP_W) return {1'b1, 10'(p + STEP_W)};
      else            return {1'b0, 10'(p - STEP_W)};
    end
  endfunction

  assign x_nxt = bounce(pic_x0, dx, 11'(H_VALID), 11'(PIC_W));
  assign y_nxt = bounce(pic_y0, dy, 11'(V_VALID), 11'(PIC_H));

  always_ff @(posedge clk) begin
    if (rst) begin
      pic_x0 <= '0;
      pic_y0 <= '0;
      dx     <= 1'b1;
      dy     <= 1'b1;
    end else if (upd) begin
      dx     <= x_nxt[10];
      pic_x0 <= x_nxt[9:0];
      dy     <= y_nxt[10];
      pic_y0 <= y_nxt[9:0];
    end
  end

endmodule

// File: rtl/vga_pic_sched.sv
// Picture ROM scheduler for the VGA pixel path: window hit, ROM addressing, latency alignment.
// Optional border ring enabled by defining VGA_PIC_SCHED_BORDER_EN.
module vga_pic_sched
  import vga_pic_pkg::*;
#(
  parameter int          H_VALID  = H_VALID_DEF,
  parameter int          V_VALID  = V_VALID_DEF,
  parameter int          PIC_W    = 100,
  parameter int          PIC_H    = 100,
  parameter int          ADDR_W   = 14,
  parameter int          ROM_LAT  = 2,
  parameter int          STEP     = 2,
  parameter logic [15:0] BG_COLOR = COLOR_BG
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  input  logic              move_en,
  input  logic [15:0]       rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rden,
  output logic [15:0]       pix_data,
  output logic [9:0]        pic_x0,
  output logic [9:0]        pic_y0
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIC_W * PIC_H - 1);
  localparam int                STAGES    = ROM_LAT;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] c);
    return (c == ADDR_LAST) ? c : c + 1'b1;
  endfunction

  state_t            state;
  state_t            state_n;
  logic              frame_start;
  logic              frame_end;
  logic              scan_en;
  logic              in_win;
  logic              upd;
  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic [ADDR_W-1:0] addr_cnt;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] win_p;

  assign frame_start = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign frame_end   = pix_valid && (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
  assign x_end       = {1'b0, pic_x0} + 11'(PIC_W - 1);
  assign y_end       = {1'b0, pic_y0} + 11'(PIC_H - 1);
  assign in_win      = scan_en && pix_valid &&
                       (pix_x >= pic_x0) && ({1'b0, pix_x} <= x_end) &&
                       (pix_y >= pic_y0) && ({1'b0, pix_y} <= y_end);
  assign upd         = (state == ST_UPDATE) && move_en;

`ifdef VGA_PIC_SCHED_BORDER_EN
  logic              brd;
  logic [STAGES-1:0] brd_p;
  assign brd = in_win && ((pix_x == pic_x0) || ({1'b0, pix_x} == x_end) ||
                          (pix_y == pic_y0) || ({1'b0, pix_y} == y_end));
`endif

  always_ff @(posedge vga_clk) begin
    if (sys_rst) state <= ST_WAIT;
    else         state <= state_n;
  end

  // Pixels seen in ST_WAIT (a partial frame after reset) never touch the counter.
  always_comb begin
    state_n = state;
    scan_en = 1'b0;
    case (state)
      ST_WAIT: begin
        scan_en = frame_start;
        if (frame_start) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        scan_en = 1'b1;
        if (frame_end) state_n = ST_UPDATE;
      end
      ST_UPDATE: state_n = ST_ACTIVE;
      default:   state_n = ST_WAIT;
    endcase
  end

  vga_pic_mover #(
    .H_VALID (H_VALID),
    .V_VALID (V_VALID),
    .PIC_W   (PIC_W),
    .PIC_H   (PIC_H),
    .STEP    (STEP)
  ) u_mover (
    .clk    (vga_clk),
    .rst    (sys_rst),
    .upd    (upd),
    .pic_x0 (pic_x0),
    .pic_y0 (pic_y0)
  );

  // Stage 0: ROM address issue
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      addr_cnt <= '0;
      rom_addr <= '0;
      rom_rden <= 1'b0;
    end else begin
      rom_rden <= in_win;
      if (in_win) rom_addr <= addr_cnt;
      if (state == ST_UPDATE) addr_cnt <= '0;
      else if (in_win)        addr_cnt <= sat_inc(addr_cnt);
    end
  end

  // Stages 0..ROM_LAT-1 track the ROM read; final stage muxes rom_q into pix_data
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      vld_p    <= '0;
      win_p    <= '0;
      pix_data <= '0;
`ifdef VGA_PIC_SCHED_BORDER_EN
      brd_p    <= '0;
`endif
    end else begin
      vld_p[0] <= pix_valid;
      win_p[0] <= in_win;
`ifdef VGA_PIC_SCHED_BORDER_EN
      brd_p[0] <= brd;
`endif
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        win_p[i] <= win_p[i-1];
`ifdef VGA_PIC_SCHED_BORDER_EN
        brd_p[i] <= brd_p[i-1];
`endif
      end
      if (!vld_p[STAGES-1])          pix_data <= '0;
`ifdef VGA_PIC_SCHED_BORDER_EN
      else if (brd_p[STAGES-1])      pix_data <= COLOR_BORDER;
`endif
      else if (win_p[STAGES-1])      pix_data <= rom_q;
      else                           pix_data <= BG_COLOR;
    end
  end

endmodule
